multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter OP_W, default 7: opcode width; opcode values zero-extended to OP_W.
REQ-002 SHALL have parameter MAX_WAIT, default 15: consecutive mem_ready-low cycles tolerated before ERROR; 0 disables timeout.
REQ-003 SHALL have port clk  in  1: single clock, rising edge.
REQ-004 SHALL have port rst  in  1: asynchronous, active-low reset.
REQ-005 SHALL have ports op in OP_W (opcode); f3 in 3 (funct3); zero in 1; sign_bit in 1 (ALU result flags).
REQ-006 SHALL have port mem_ready  in  1: memory completes current access this cycle.
REQ-007 SHALL have 1-bit outputs pc_write, old_pc_write, ir_write, adr_sel (0 pc, 1 alu_out), mem_read, mem_write, reg_write, pc_src (0 ALU result, 1 alu_out), done, err.
REQ-008 SHALL have outputs alu_src_a[1:0] (00 pc, 01 old_pc, 10 rs1) and alu_src_b[1:0] (00 rs2, 01 imm, 10 const 4).
REQ-009 SHALL have outputs alu_ctrl[2:0] (000 ADD, 001 SUB, else f3), imm_sel[2:0] (I 000, S 001, B 010, J 011, U 100), result_sel[1:0] (00 alu_out, 01 mem data, 10 ALU result, 11 imm).

Function
REQ-010 Opcodes SHALL be: R 0, LW 1, ADDI 2, XORI 3, ORI 4, SLTI 5, JALR 6, SW 7, JAL 8, BEQ 9, BNE 10, BLT 11, BGE 12, LUI 13.
REQ-011 States SHALL be FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR_ADR, LUI, HALT, ERROR; unlisted outputs 0 in every state.
REQ-012 FETCH: mem_read=1, adr_sel=0, src_a=00, src_b=10, ADD, pc_src=0; pc_write, ir_write, old_pc_write = mem_ready; mem_ready -> DECODE, else stay.
REQ-013 DECODE: src_a=01, src_b=01, ADD, imm_sel J if op=JAL else B; next by op: R->EXEC_R, ADDI/XORI/ORI/SLTI->EXEC_I, LW/SW->MEM_ADR, B-type->BRANCH, JAL->JAL, JALR->JALR_ADR, LUI->LUI, else ERROR.
REQ-014 EXEC_R: src_a=10, src_b=00, alu_ctrl=f3 -> ALU_WB. EXEC_I: src_a=10, src_b=01, imm I, alu_ctrl=f3 -> ALU_WB. ALU_WB: reg_write, result_sel=00 -> FETCH.
REQ-015 MEM_ADR: src_a=10, src_b=01, ADD, imm I for LW / S for SW -> MEM_RD (LW) or MEM_WR (SW).
REQ-016 MEM_RD: adr_sel=1, mem_read=1; mem_ready -> MEM_WB. MEM_WB: reg_write, result_sel=01 -> FETCH. MEM_WR: adr_sel=1, mem_write=1; mem_ready -> FETCH.
REQ-017 BRANCH: src_a=10, src_b=00, SUB, pc_src=1; pc_write = BEQ zero, BNE ~zero, BLT sign_bit, BGE ~sign_bit -> FETCH.
REQ-018 JAL: src_a=01, src_b=10, ADD, reg_write, result_sel=10, pc_write, pc_src=1 -> FETCH. JALR_ADR: src_a=10, src_b=01, imm I, ADD -> JAL.
REQ-019 LUI: imm U, reg_write, result_sel=11 -> FETCH.
REQ-020 Wait counter (ceil(log2(MAX_WAIT+1)) bits, saturating) SHALL count consecutive mem_ready-low cycles in FETCH/MEM_RD/MEM_WR, clear on mem_ready or state exit; if count reaches MAX_WAIT with mem_ready low -> ERROR.
REQ-021 ERROR SHALL assert err=1, all strobes 0, remain until reset. HALT SHALL assert done=1, all strobes 0, remain until reset.
REQ-022 mem_ready is sampled only in FETCH/MEM_RD/MEM_WR; mem_ready high together with timeout SHALL complete the access, not error.

Reset
REQ-023 rst low SHALL immediately force FETCH, wait counter 0, done=0, err=0, regardless of state or pending access.
REQ-024 During reset all strobes (pc_write, ir_write, reg_write, mem_write, old_pc_write) SHALL be 0; mem_read becomes 1 only on FETCH after rst rises... while rst low mem_read=0.

Configuration
REQ-025 With HALT_OP_EN defined, op = all-ones SHALL go DECODE -> HALT; without it all-ones is illegal and SHALL go to ERROR.

Verification
REQ-026 ADDI, mem_ready=1 throughout -> FETCH, DECODE, EXEC_I, ALU_WB; reg_write=1 exactly in cycle 4, alu_ctrl=f3.
REQ-027 LW, mem_ready low 3 cycles in MEM_RD -> stays 3 extra cycles, MEM_WB reg_write result_sel=01, back to FETCH.
REQ-028 BNE zero=1 -> pc_write=0 in BRANCH; BLT sign_bit=1 -> pc_write=1, pc_src=1.
REQ-029 MAX_WAIT=4, mem_ready held low in FETCH -> ERROR after 4 cycles, err=1 sticky; rst low clears to FETCH.
REQ-030 op=7'h7F -> done=1 with HALT_OP_EN, err=1 without; JAL -> reg_write and pc_write same cycle, result_sel=10.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Handshake/control bundle between the datapath (master) and the multicycle controller (slave).
interface multicycle_controller_if #(
  parameter int OP_W = 7
);
  logic [OP_W-1:0] op;
  logic [2:0]      f3;
  logic            zero;
  logic            sign_bit;
  logic            mem_ready;

  logic            pc_write;
  logic            old_pc_write;
  logic            ir_write;
  logic            adr_sel;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic            pc_src;
  logic            done;
  logic            err;
  logic [1:0]      alu_src_a;
  logic [1:0]      alu_src_b;
  logic [2:0]      alu_ctrl;
  logic [2:0]      imm_sel;
  logic [1:0]      result_sel;

  // mem_ready is a completion strobe: an access in FETCH/MEM_RD/MEM_WR finishes in the
  // cycle the controller sees mem_ready high while it drives mem_read or mem_write.
  modport master (
    output op, f3, zero, sign_bit, mem_ready,
    input  pc_write, old_pc_write, ir_write, adr_sel, mem_read, mem_write, reg_write,
           pc_src, done, err, alu_src_a, alu_src_b, alu_ctrl, imm_sel, result_sel
  );

  modport slave (
    input  op, f3, zero, sign_bit, mem_ready,
    output pc_write, old_pc_write, ir_write, adr_sel, mem_read, mem_write, reg_write,
           pc_src, done, err, alu_src_a, alu_src_b, alu_ctrl, imm_sel, result_sel
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM with memory wait timeout; state visible on state_o.
// Define HALT_OP_EN to make the all-ones opcode halt (done) instead of trapping to ERROR.
module multicycle_controller #(
  parameter int OP_W     = 7,
  parameter int MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.slave bus,
  output logic [3:0]             state_o
);
  localparam int WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int WAIT_LIM = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(2);
  localparam logic [OP_W-1:0] OP_XORI = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(5);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(13);
`ifdef HALT_OP_EN
  localparam logic [OP_W-1:0] OP_HALT = {OP_W{1'b1}};
`endif

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_BRANCH, S_JAL, S_JALR_ADR, S_LUI, S_HALT, S_ERROR
  } state_t;

  state_t            state_q;
  state_t            decode_nxt;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              mem_phase;
  logic              timeout;

  assign state_o   = state_q;
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Timeout fires on the MAX_WAIT-th consecutive low cycle; a ready in that cycle still wins.
  assign timeout   = (MAX_WAIT > 0) && mem_phase && !bus.mem_ready &&
                     (wait_q >= WAIT_W'(WAIT_LIM));

  always_comb begin
    wait_d = '0;
    if (mem_phase && !bus.mem_ready && !timeout) begin
      wait_d = (wait_q != '1) ? wait_q + 1'b1 : wait_q;
    end
  end

  always_comb begin
    decode_nxt = S_ERROR;
    case (bus.op)
      OP_R:                             decode_nxt = S_EXEC_R;
      OP_ADDI, OP_XORI, OP_ORI, OP_SLTI: decode_nxt = S_EXEC_I;
      OP_LW, OP_SW:                     decode_nxt = S_MEM_ADR;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE:   decode_nxt = S_BRANCH;
      OP_JAL:                           decode_nxt = S_JAL;
      OP_JALR:                          decode_nxt = S_JALR_ADR;
      OP_LUI:                           decode_nxt = S_LUI;
`ifdef HALT_OP_EN
      OP_HALT:                          decode_nxt = S_HALT;
`endif
      default:                          decode_nxt = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      wait_q <= wait_d;
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready)  state_q <= S_DECODE;
          else if (timeout)   state_q <= S_ERROR;
        end
        S_DECODE:             state_q <= decode_nxt;
        S_EXEC_R, S_EXEC_I:   state_q <= S_ALU_WB;
        S_MEM_ADR:            state_q <= (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (bus.mem_ready)  state_q <= S_MEM_WB;
          else if (timeout)   state_q <= S_ERROR;
        end
        S_MEM_WR: begin
          if (bus.mem_ready)  state_q <= S_FETCH;
          else if (timeout)   state_q <= S_ERROR;
        end
        S_JALR_ADR:           state_q <= S_JAL;
        S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_LUI: state_q <= S_FETCH;
        S_HALT, S_ERROR:      state_q <= state_q;
        default:              state_q <= S_ERROR;
      endcase
    end
  end

  // Outputs decode the registered state; FETCH strobes follow mem_ready in the same cycle,
  // and everything is forced low while rst is held.
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.old_pc_write = 1'b0;
    bus.ir_write     = 1'b0;
    bus.adr_sel      = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.pc_src       = 1'b0;
    bus.done         = 1'b0;
    bus.err          = 1'b0;
    bus.alu_src_a    = 2'b00;
    bus.alu_src_b    = 2'b00;
    bus.alu_ctrl     = ALU_ADD;
    bus.imm_sel      = IMM_I;
    bus.result_sel   = 2'b00;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read     = 1'b1;
          bus.alu_src_b    = B_FOUR;
          bus.pc_write     = bus.mem_ready;
          bus.ir_write     = bus.mem_ready;
          bus.old_pc_write = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = A_OLDPC;
          bus.alu_src_b = B_IMM;
          bus.imm_sel   = (bus.op == OP_JAL) ? IMM_J : IMM_B;
        end
        S_EXEC_R: begin
          bus.alu_src_a = A_RS1;
          bus.alu_ctrl  = bus.f3;
        end
        S_EXEC_I: begin
          bus.alu_src_a = A_RS1;
          bus.alu_src_b = B_IMM;
          bus.alu_ctrl  = bus.f3;
        end
        S_ALU_WB: bus.reg_write = 1'b1;
        S_MEM_ADR: begin
          bus.alu_src_a = A_RS1;
          bus.alu_src_b = B_IMM;
          bus.imm_sel   = (bus.op == OP_SW) ? IMM_S : IMM_I;
        end
        S_MEM_RD: begin
          bus.adr_sel  = 1'b1;
          bus.mem_read = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.result_sel = 2'b01;
        end
        S_MEM_WR: begin
          bus.adr_sel   = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = A_RS1;
          bus.alu_ctrl  = ALU_SUB;
          bus.pc_src    = 1'b1;
          case (bus.op)
            OP_BEQ:  bus.pc_write = bus.zero;
            OP_BNE:  bus.pc_write = ~bus.zero;
            OP_BLT:  bus.pc_write = bus.sign_bit;
            OP_BGE:  bus.pc_write = ~bus.sign_bit;
            default: bus.pc_write = 1'b0;
          endcase
        end
        S_JAL: begin
          bus.alu_src_a  = A_OLDPC;
          bus.alu_src_b  = B_FOUR;
          bus.reg_write  = 1'b1;
          bus.result_sel = 2'b10;
          bus.pc_write   = 1'b1;
          bus.pc_src     = 1'b1;
        end
        S_JALR_ADR: begin
          bus.alu_src_a = A_RS1;
          bus.alu_src_b = B_IMM;
        end
        S_LUI: begin
          bus.imm_sel    = IMM_U;
          bus.reg_write  = 1'b1;
          bus.result_sel = 2'b11;
        end
        S_HALT:  bus.done = 1'b1;
        S_ERROR: bus.err  = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: instruction-level reference model expands each opcode into its cycle plan.
module tb_multicycle_controller;
  localparam int OP_W = 7;
  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC_R = 2, PH_EXEC_I = 3, PH_ALU_WB = 4;
  localparam int PH_MEM_ADR = 5, PH_MEM_RD = 6, PH_MEM_WB = 7, PH_MEM_WR = 8, PH_BRANCH = 9;
  localparam int PH_JAL = 10, PH_JALR = 11, PH_LUI = 12, PH_HALT = 13, PH_ERROR = 14;
`ifdef HALT_OP_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write, old_pc_write, ir_write, adr_sel, mem_read;
    logic       mem_write, reg_write, pc_src, done, err;
    logic [1:0] src_a, src_b;
    logic [2:0] alu_ctrl, imm_sel;
    logic [1:0] result_sel;
  } ctrl_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst, rst2;
  logic [3:0] st1, st2;

  multicycle_controller_if #(.OP_W(OP_W)) bus ();
  multicycle_controller_if #(.OP_W(OP_W)) bus2 ();

  multicycle_controller #(.OP_W(OP_W), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(st1));
  multicycle_controller #(.OP_W(OP_W), .MAX_WAIT(4)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2), .state_o(st2));

  ctrl_t obs1, obs2;
  assign obs1 = {bus.pc_write, bus.old_pc_write, bus.ir_write, bus.adr_sel, bus.mem_read,
                 bus.mem_write, bus.reg_write, bus.pc_src, bus.done, bus.err, bus.alu_src_a,
                 bus.alu_src_b, bus.alu_ctrl, bus.imm_sel, bus.result_sel};
  assign obs2 = {bus2.pc_write, bus2.old_pc_write, bus2.ir_write, bus2.adr_sel, bus2.mem_read,
                 bus2.mem_write, bus2.reg_write, bus2.pc_src, bus2.done, bus2.err, bus2.alu_src_a,
                 bus2.alu_src_b, bus2.alu_ctrl, bus2.imm_sel, bus2.result_sel};

  // scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [21:0] exp_q[$];
  logic        rdy_q[$];
  string       tag_q[$];
  int          cur_op;
  logic [2:0]  cur_f3;
  logic        cur_z, cur_s;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: control word required in a given step of an instruction.
  function automatic ctrl_t exp_for(int ph, logic rdy, int op, logic [2:0] f3, logic z, logic s);
    ctrl_t c;
    c = '0;
    case (ph)
      PH_FETCH:   begin c.mem_read = 1; c.src_b = 2; c.pc_write = rdy; c.ir_write = rdy;
                        c.old_pc_write = rdy; end
      PH_DECODE:  begin c.src_a = 1; c.src_b = 1; c.imm_sel = (op == 8) ? 3'd3 : 3'd2; end
      PH_EXEC_R:  begin c.src_a = 2; c.alu_ctrl = f3; end
      PH_EXEC_I:  begin c.src_a = 2; c.src_b = 1; c.alu_ctrl = f3; end
      PH_ALU_WB:  c.reg_write = 1;
      PH_MEM_ADR: begin c.src_a = 2; c.src_b = 1; c.imm_sel = (op == 7) ? 3'd1 : 3'd0; end
      PH_MEM_RD:  begin c.adr_sel = 1; c.mem_read = 1; end
      PH_MEM_WB:  begin c.reg_write = 1; c.result_sel = 1; end
      PH_MEM_WR:  begin c.adr_sel = 1; c.mem_write = 1; end
      PH_BRANCH:  begin
        c.src_a = 2; c.alu_ctrl = 1; c.pc_src = 1;
        c.pc_write = (op == 9) ? z : (op == 10) ? !z : (op == 11) ? s : !s;
      end
      PH_JAL:     begin c.src_a = 1; c.src_b = 2; c.reg_write = 1; c.result_sel = 2;
                        c.pc_write = 1; c.pc_src = 1; end
      PH_JALR:    begin c.src_a = 2; c.src_b = 1; end
      PH_LUI:     begin c.imm_sel = 4; c.reg_write = 1; c.result_sel = 3; end
      PH_HALT:    c.done = 1;
      default:    c.err = 1;
    endcase
    return c;
  endfunction

  task automatic push(int ph, logic rdy, string tag);
    exp_q.push_back(exp_for(ph, rdy, cur_op, cur_f3, cur_z, cur_s));
    rdy_q.push_back(rdy);
    tag_q.push_back(tag);
  endtask

  task automatic push_mem(int ph, int stalls, string tag);
    for (int i = 0; i < stalls; i++) push(ph, 1'b0, {tag, " wait"});
    push(ph, 1'b1, {tag, " done"});
  endtask

  // Expand the current instruction into its expected cycle sequence.
  task automatic plan_instr(int fs, int ms);
    push_mem(PH_FETCH, fs, "fetch");
    push(PH_DECODE, rb(), "decode");
    case (cur_op)
      0:          begin push(PH_EXEC_R, rb(), "exec_r"); push(PH_ALU_WB, rb(), "alu_wb"); end
      2, 3, 4, 5: begin push(PH_EXEC_I, rb(), "exec_i"); push(PH_ALU_WB, rb(), "alu_wb"); end
      1: begin push(PH_MEM_ADR, rb(), "mem_adr"); push_mem(PH_MEM_RD, ms, "mem_rd");
               push(PH_MEM_WB, rb(), "mem_wb"); end
      7: begin push(PH_MEM_ADR, rb(), "mem_adr"); push_mem(PH_MEM_WR, ms, "mem_wr"); end
      9, 10, 11, 12: push(PH_BRANCH, rb(), "branch");
      8:  push(PH_JAL, rb(), "jal");
      6:  begin push(PH_JALR, rb(), "jalr_adr"); push(PH_JAL, rb(), "jal"); end
      13: push(PH_LUI, rb(), "lui");
      default: begin
        for (int i = 0; i < 3; i++) begin
          if (cur_op == 127 && HALT_EN) push(PH_HALT, rb(), "halt");
          else push(PH_ERROR, rb(), "error");
        end
      end
    endcase
  endtask

  // driver: entered at a negedge; drives, samples 1ns later, moves to the next negedge
  task automatic drain(int n);
    string t;
    while (exp_q.size() > 0 && n != 0) begin
      bus.op        = OP_W'(cur_op);
      bus.f3        = cur_f3;
      bus.zero      = cur_z;
      bus.sign_bit  = cur_s;
      bus.mem_ready = rdy_q.pop_front();
      #1;
      t = tag_q.pop_front();
      check($sformatf("op%0d %s", cur_op, t), 32'(obs1), 32'(exp_q.pop_front()));
      @(negedge clk);
      n--;
    end
  endtask

  task automatic run(int op, int f3, logic z, logic s, int fs, int ms);
    cur_op = op; cur_f3 = 3'(f3); cur_z = z; cur_s = s;
    plan_instr(fs, ms);
    drain(1000);
  endtask

  task automatic do_reset1();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("reset outputs low", 32'(obs1), 32'(0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step2(ctrl_t e, logic rdy, string tag);
    bus2.mem_ready = rdy;
    #1;
    check(tag, 32'(obs2), 32'(e));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    bus.op = '0; bus.f3 = '0; bus.zero = 0; bus.sign_bit = 0; bus.mem_ready = 0;
    bus2.op = '0; bus2.f3 = '0; bus2.zero = 0; bus2.sign_bit = 0; bus2.mem_ready = 0;
    @(negedge clk);
    do_reset1();

    run(2, 5, 0, 0, 0, 0);     // ADDI, no stalls
    run(1, 2, 0, 0, 0, 3);     // LW with three MEM_RD waits
    run(10, 0, 1, 0, 0, 0);    // BNE not taken
    run(11, 0, 0, 1, 0, 0);    // BLT taken
    run(8, 0, 0, 0, 1, 0);     // JAL
    run(6, 0, 0, 0, 0, 0);     // JALR
    run(7, 0, 0, 0, 2, 2);     // SW with waits
    run(13, 0, 0, 0, 0, 0);    // LUI
    run(0, 7, 0, 0, 0, 0);     // R-type

    for (int i = 0; i < 40; i++) begin
      run($urandom_range(0, 13), $urandom_range(0, 7), rb(), rb(),
          $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // reset in the middle of a stalled load, then resume cleanly
    cur_op = 1; cur_f3 = 0; cur_z = 0; cur_s = 0;
    plan_instr(0, 6);
    drain(5);
    exp_q.delete(); rdy_q.delete(); tag_q.delete();
    do_reset1();
    run(3, 4, 0, 0, 0, 0);

    run($urandom_range(14, 126), 0, 0, 0, 0, 0);   // illegal opcode -> sticky err
    do_reset1();
    run(127, 0, 0, 0, 0, 0);                        // all-ones opcode
    do_reset1();
    run($urandom_range(0, 13), $urandom_range(0, 7), rb(), rb(), 1, 1);

    // MAX_WAIT=4 instance: late ready completes, four low cycles trap
    check("t2 reset outputs low", 32'(obs2), 32'(0));
    rst2 = 1'b1;
    bus2.op = OP_W'(2); bus2.f3 = 3'd6;
    for (int i = 0; i < 3; i++) step2(exp_for(PH_FETCH, 0, 2, 6, 0, 0), 1'b0, "t2 fetch wait");
    step2(exp_for(PH_FETCH, 1, 2, 6, 0, 0), 1'b1, "t2 fetch ready at limit");
    step2(exp_for(PH_DECODE, 0, 2, 6, 0, 0), rb(), "t2 decode");
    step2(exp_for(PH_EXEC_I, 0, 2, 6, 0, 0), rb(), "t2 exec_i");
    step2(exp_for(PH_ALU_WB, 0, 2, 6, 0, 0), rb(), "t2 alu_wb");
    for (int i = 0; i < 4; i++) step2(exp_for(PH_FETCH, 0, 2, 6, 0, 0), 1'b0, "t2 fetch stall");
    for (int i = 0; i < 3; i++) step2(exp_for(PH_ERROR, 0, 2, 6, 0, 0), rb(), "t2 error sticky");
    rst2 = 1'b0;
    #1;
    check("t2 reset clears err", 32'(obs2), 32'(0));
    @(negedge clk);
    rst2 = 1'b1;
    step2(exp_for(PH_FETCH, 1, 2, 6, 0, 0), 1'b1, "t2 fetch after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
